// File: rtl/mic_sequencer_pkg.sv
// Shared definitions for the MIC-1 microsequencer.
// Control-store geometry, MIR field offsets and sequencer states.
package mic_sequencer_pkg;

    localparam int MPC_BITS = 9;
    localparam int MIR_BITS = 36;

    localparam int NA_LSB   = 27;
    localparam int JMPC_BIT = 26;
    localparam int JAMN_BIT = 25;
    localparam int JAMZ_BIT = 24;

    typedef enum logic [1:0] {
        LOAD,
        RUN,
        WAIT,
        ERROR
    } seq_state_t;

endpackage

// File: rtl/mic_sequencer_mpc_next_logic.sv
// Next-MPC computation for the MIC-1 microsequencer.
// Jump bits OR into the next address; there are never carries.
module mpc_next_logic
    import mic_sequencer_pkg::*;
(
    input  logic [MPC_BITS-1:0] na_i,
    input  logic                jmpc_i,
    input  logic                jamn_i,
    input  logic                jamz_i,
    input  logic                n_i,
    input  logic                z_i,
    input  logic [7:0]          mbr_i,
    output logic [MPC_BITS-1:0] nxt_o
);

    assign nxt_o[8]   = na_i[8] | (jamn_i & n_i) | (jamz_i & z_i);
    assign nxt_o[7:0] = na_i[7:0] | (jmpc_i ? mbr_i : 8'h00);

endmodule

// File: rtl/mic_sequencer.sv
// MIC-1 microsequencer: MPC/MIR/flag registers, stall hold and
// a sticky watchdog that traps overly long memory stalls.
module mic_sequencer #(
    parameter int MPC_BITS = 9,
    parameter int MIR_BITS = 36,
    parameter int WAIT_MAX = 15
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                n,
    input  logic                z,
    input  logic [7:0]          mbr,
    input  logic                stall,
    input  logic [MIR_BITS-1:0] cs_data,
    output logic [MPC_BITS-1:0] cs_addr,
    output logic [MIR_BITS-1:0] mir,
    output logic [MPC_BITS-1:0] mpc,
    output logic                n_flag,
    output logic                z_flag,
    output logic                exec_en,
    output logic                timeout
);
    import mic_sequencer_pkg::*;

    localparam int CNT_BITS = $clog2(WAIT_MAX + 1);

    seq_state_t          state_q;
    logic [MPC_BITS-1:0] mpc_q;
    logic [MIR_BITS-1:0] mir_q;
    logic                n_q;
    logic                z_q;
    logic [CNT_BITS-1:0] cnt_q;
    logic                timeout_q;
    logic [MPC_BITS-1:0] nxt;

    mpc_next_logic u_next (
        .na_i   (mir_q[NA_LSB +: MPC_BITS]),
        .jmpc_i (mir_q[JMPC_BIT]),
        .jamn_i (mir_q[JAMN_BIT]),
        .jamz_i (mir_q[JAMZ_BIT]),
        .n_i    (n),
        .z_i    (z),
        .mbr_i  (mbr),
        .nxt_o  (nxt)
    );

    // LOAD always fetches the entry word at address 0
    assign cs_addr = (state_q == LOAD) ? '0 : nxt;
    assign exec_en = ((state_q == RUN) || (state_q == WAIT)) && !stall;
    assign mir     = mir_q;
    assign mpc     = mpc_q;
    assign n_flag  = n_q;
    assign z_flag  = z_q;
    assign timeout = timeout_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= LOAD;
            mpc_q     <= '0;
            mir_q     <= '0;
            n_q       <= 1'b0;
            z_q       <= 1'b0;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            case (state_q)
                LOAD: begin
                    mir_q   <= cs_data;
                    mpc_q   <= '0;
                    state_q <= RUN;
                end
                RUN: begin
                    if (stall) begin
                        cnt_q   <= CNT_BITS'(1);
                        state_q <= WAIT;
                    end else begin
                        mpc_q <= nxt;
                        mir_q <= cs_data;
                        n_q   <= n;
                        z_q   <= z;
                    end
                end
                WAIT: begin
                    if (!stall) begin
                        mpc_q   <= nxt;
                        mir_q   <= cs_data;
                        n_q     <= n;
                        z_q     <= z;
                        cnt_q   <= '0;
                        state_q <= RUN;
                    end else if (cnt_q < CNT_BITS'(WAIT_MAX)) begin
                        cnt_q <= cnt_q + 1'b1;
                    end else begin
                        timeout_q <= 1'b1;
                        state_q   <= ERROR;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mic_sequencer.sv
// Directed bench for mic_sequencer: next-address vectors from a table,
// then hand-written stall, watchdog and reset-in-stall sequences.
module tb_mic_sequencer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        n;
    logic        z;
    logic [7:0]  mbr;
    logic        stall;
    logic [35:0] cs_data;
    logic [8:0]  cs_addr;
    logic [35:0] mir;
    logic [8:0]  mpc;
    logic        n_flag;
    logic        z_flag;
    logic        exec_en;
    logic        timeout;

    logic [35:0] cs_mem [512];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    assign cs_data = cs_mem[cs_addr];

    mic_sequencer dut (
        .clk     (clk),
        .reset_n (reset_n),
        .n       (n),
        .z       (z),
        .mbr     (mbr),
        .stall   (stall),
        .cs_data (cs_data),
        .cs_addr (cs_addr),
        .mir     (mir),
        .mpc     (mpc),
        .n_flag  (n_flag),
        .z_flag  (z_flag),
        .exec_en (exec_en),
        .timeout (timeout)
    );

    typedef struct {
        logic [35:0] mir_nxt;
        logic        vn;
        logic        vz;
        logic [7:0]  vmbr;
        logic [8:0]  exp;
    } vec_t;

    vec_t vecs [10];

    function automatic logic [35:0] w(input logic [8:0] na, input logic j,
                                      input logic jn, input logic jz,
                                      input logic [23:0] low);
        return {na, j, jn, jz, low};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [8:0]  hold_mpc;
        logic [35:0] hold_mir;

        for (int i = 0; i < 512; i++) cs_mem[i] = '0;
        cs_mem[0] = 36'h0A5000000;
        reset_n = 1'b0;
        n = 1'b0;
        z = 1'b0;
        mbr = 8'h00;
        stall = 1'b0;

        vecs[0] = '{w(9'h005, 0, 0, 1, 24'h123456), 0, 1, 8'h03, 9'h117};
        vecs[1] = '{w(9'h005, 0, 0, 1, 24'h654321), 0, 1, 8'hFF, 9'h105};
        vecs[2] = '{w(9'h000, 1, 0, 0, 24'h0000AA), 1, 0, 8'h00, 9'h005};
        vecs[3] = '{w(9'h001, 1, 0, 0, 24'h000000), 0, 0, 8'h60, 9'h060};
        vecs[4] = '{w(9'h010, 0, 1, 0, 24'h000000), 0, 0, 8'h60, 9'h061};
        vecs[5] = '{w(9'h010, 0, 1, 0, 24'hFFFFFF), 1, 0, 8'h00, 9'h110};
        vecs[6] = '{w(9'h0F0, 1, 1, 1, 24'h000000), 0, 1, 8'h00, 9'h010};
        vecs[7] = '{w(9'h100, 0, 0, 0, 24'h000000), 1, 1, 8'h0F, 9'h1FF};
        vecs[8] = '{w(9'h1AA, 1, 0, 0, 24'h000000), 0, 0, 8'hFF, 9'h100};
        vecs[9] = '{w(9'h042, 0, 0, 0, 24'h000000), 1, 0, 8'h55, 9'h1FF};

        // reset held for two edges
        tick();
        tick();
        chk("rst_mpc", 64'(mpc), 64'h0);
        chk("rst_mir", 64'(mir), 64'h0);
        chk("rst_exec", 64'(exec_en), 64'h0);
        chk("rst_tmo", 64'(timeout), 64'h0);
        chk("rst_flags", 64'({n_flag, z_flag}), 64'h0);

        @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk("load_exec", 64'(exec_en), 64'h0);
        chk("load_addr", 64'(cs_addr), 64'h0);
        tick();
        chk("load_mir", 64'(mir), 64'h0A5000000);
        chk("load_mpc", 64'(mpc), 64'h0);
        chk("load_exec1", 64'(exec_en), 64'h1);

        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n = vecs[i].vn;
            z = vecs[i].vz;
            mbr = vecs[i].vmbr;
            cs_mem[vecs[i].exp] = vecs[i].mir_nxt;
            #1;
            chk($sformatf("v%0d_addr", i), 64'(cs_addr), 64'(vecs[i].exp));
            chk($sformatf("v%0d_exec", i), 64'(exec_en), 64'h1);
            tick();
            chk($sformatf("v%0d_mpc", i), 64'(mpc), 64'(vecs[i].exp));
            chk($sformatf("v%0d_mir", i), 64'(mir), 64'(vecs[i].mir_nxt));
            chk($sformatf("v%0d_nz", i), 64'({n_flag, z_flag}),
                64'({vecs[i].vn, vecs[i].vz}));
        end

        // three stalled cycles hold everything
        @(negedge clk);
        stall = 1'b1;
        n = 1'b0;
        z = 1'b1;
        mbr = 8'h00;
        cs_mem[9'h042] = w(9'h043, 0, 0, 0, 24'h0000C3);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("st%0d_exec", i), 64'(exec_en), 64'h0);
            tick();
            chk($sformatf("st%0d_mpc", i), 64'(mpc), 64'h1FF);
            chk($sformatf("st%0d_mir", i), 64'(mir),
                64'(w(9'h042, 0, 0, 0, 24'h0)));
            chk($sformatf("st%0d_nz", i), 64'({n_flag, z_flag}), 64'h2);
            @(negedge clk);
        end
        chk("st_cnt3", 64'(dut.cnt_q), 64'h3);
        stall = 1'b0;
        #1;
        chk("st_resume_exec", 64'(exec_en), 64'h1);
        chk("st_resume_addr", 64'(cs_addr), 64'h042);
        tick();
        chk("st_resume_mpc", 64'(mpc), 64'h042);
        chk("st_resume_mir", 64'(mir), 64'(w(9'h043, 0, 0, 0, 24'h0000C3)));
        chk("st_resume_nz", 64'({n_flag, z_flag}), 64'h1);
        chk("st_cnt0", 64'(dut.cnt_q), 64'h0);

        // 15 stalled edges are tolerated
        @(negedge clk);
        cs_mem[9'h043] = w(9'h044, 0, 0, 0, 24'h0);
        stall = 1'b1;
        repeat (15) tick();
        chk("wd15_tmo", 64'(timeout), 64'h0);
        chk("wd15_cnt", 64'(dut.cnt_q), 64'hF);
        @(negedge clk);
        stall = 1'b0;
        #1;
        chk("wd15_exec", 64'(exec_en), 64'h1);
        tick();
        chk("wd15_mpc", 64'(mpc), 64'h043);
        chk("wd15_tmo2", 64'(timeout), 64'h0);

        // the 16th stalled edge trips the watchdog
        @(negedge clk);
        stall = 1'b1;
        repeat (15) tick();
        chk("wd16_pre", 64'(timeout), 64'h0);
        tick();
        chk("wd16_tmo", 64'(timeout), 64'h1);
        chk("wd16_exec", 64'(exec_en), 64'h0);
        hold_mpc = mpc;
        hold_mir = mir;
        chk("wd16_mpc", 64'(hold_mpc), 64'h043);
        @(negedge clk);
        stall = 1'b0;
        #1;
        chk("err_exec", 64'(exec_en), 64'h0);
        repeat (3) tick();
        chk("err_tmo_held", 64'(timeout), 64'h1);
        chk("err_mpc_held", 64'(mpc), 64'(hold_mpc));
        chk("err_mir_held", 64'(mir), 64'(hold_mir));

        @(negedge clk);
        reset_n = 1'b0;
        tick();
        chk("err_rst_tmo", 64'(timeout), 64'h0);
        chk("err_rst_mpc", 64'(mpc), 64'h0);
        chk("err_rst_mir", 64'(mir), 64'h0);
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        chk("err_load_mir", 64'(mir), 64'h0A5000000);

        // execute one word to set both flags, then stall 7 and reset
        @(negedge clk);
        n = 1'b1;
        z = 1'b1;
        mbr = 8'h00;
        cs_mem[9'h114] = w(9'h050, 0, 0, 0, 24'h0);
        tick();
        chk("ms_mpc", 64'(mpc), 64'h114);
        chk("ms_nz", 64'({n_flag, z_flag}), 64'h3);
        @(negedge clk);
        stall = 1'b1;
        repeat (7) tick();
        chk("ms_cnt7", 64'(dut.cnt_q), 64'h7);
        @(negedge clk);
        reset_n = 1'b0;
        tick();
        chk("ms_rst_mpc", 64'(mpc), 64'h0);
        chk("ms_rst_mir", 64'(mir), 64'h0);
        chk("ms_rst_nz", 64'({n_flag, z_flag}), 64'h0);
        chk("ms_rst_cnt", 64'(dut.cnt_q), 64'h0);
        chk("ms_rst_exec", 64'(exec_en), 64'h0);
        @(negedge clk);
        reset_n = 1'b1;
        stall = 1'b0;
        n = 1'b0;
        z = 1'b0;
        cs_mem[9'h014] = w(9'h060, 0, 0, 0, 24'h00BEEF);
        tick();
        chk("ms_load_mir", 64'(mir), 64'h0A5000000);
        chk("ms_load_exec", 64'(exec_en), 64'h1);
        tick();
        chk("ms_run_mpc", 64'(mpc), 64'h014);
        chk("ms_run_mir", 64'(mir), 64'(w(9'h060, 0, 0, 0, 24'h00BEEF)));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mic_sequencer.md
# mic_sequencer

Microsequencer for the MIC-1 control path. It consumes the `n`/`z` outputs of the ALU and the MBR byte, and computes the next micro-program counter (MPC) from the JAMN/JAMZ/JMPC bits of the current microinstruction. It fetches that word from the asynchronous control store and registers it as the MIR. It owns the N/Z flag registers, the memory-stall hold behaviour and a stall watchdog.

## Interface
Parameters:
- `MPC_BITS`, 9: control-store address width.
- `MIR_BITS`, 36: microinstruction width.
- `WAIT_MAX`, 15: maximum tolerated consecutive stalled cycles.

Ports:
- `clk`  in  1: single clock; all state changes on the rising edge.
- `reset_n`  in  1: reset; synchronous and active-low.
- `n`, `z`  in  1 each: live ALU flags for the microinstruction currently in the MIR.
- `mbr`  in  8: MBR byte, used by JMPC.
- `stall`  in  1: memory not ready; hold the current microinstruction.
- `cs_data`  in  `MIR_BITS`: control-store word at `cs_addr`, combinational read.
- `cs_addr`  out  `MPC_BITS`: combinational; equals the next MPC.
- `mir`  out  `MIR_BITS`: registered microinstruction.
- `mpc`  out  `MPC_BITS`: address of the word in `mir`.
- `n_flag`, `z_flag`  out  1 each: registered flags from the last executed microinstruction.
- `exec_en`  out  1: datapath may commit C-bus writes and memory requests this cycle.
- `timeout`  out  1: sticky watchdog error.

## Operation
- MIR fields:
  - [35:27] NEXT_ADDRESS
  - [26] JMPC, [25] JAMN, [24] JAMZ
  - [23:16] SLL8, SRA1, F0, F1, ENA, ENB, INVA, INC
  - [15:7] C
  - [6:4] WRITE, READ, FETCH
  - [3:0] B
- Next-address rule:
  - `nxt[8] = NA[8] | (JAMN & n) | (JAMZ & z)`
  - `nxt[7:0] = NA[7:0] | (JMPC ? mbr : 8'h00)`
  - Bitwise OR, no carries.
- `cs_addr` = `nxt`, except in LOAD where it is 0.
- States: LOAD, RUN, WAIT, ERROR.
  - LOAD (entered on reset):
    - `exec_en`=0; `stall` is ignored.
    - At the edge: `mir<=cs_data` (address 0), `mpc<=0`, go to RUN.
  - RUN, `stall`=0:
    - `exec_en`=1.
    - At the edge: `mpc<=nxt`, `mir<=cs_data`, `n_flag<=n`, `z_flag<=z`.
  - RUN, `stall`=1:
    - `exec_en`=0; `mpc`, `mir` and flags are held.
    - At the edge: `cnt<=1`, go to WAIT.
  - WAIT, `stall`=0:
    - Behaves exactly as RUN with `stall`=0.
    - At the edge: `cnt<=0`, go to RUN.
  - WAIT, `stall`=1:
    - `exec_en`=0; everything is held.
    - If `cnt`<`WAIT_MAX`: `cnt<=cnt+1`.
    - Else go to ERROR.
  - ERROR:
    - `timeout`=1, `exec_en`=0; all registers frozen.
    - Left only by reset.
- Watchdog limit: at most `WAIT_MAX` consecutive stalled edges are tolerated; the (`WAIT_MAX`+1)th causes ERROR.
- Reset values:
  - `mpc`=0, `mir`=0 (NOP), `n_flag`=`z_flag`=0
  - `cnt`=0, `timeout`=0, `exec_en`=0, state LOAD
- Reset mid-operation (any state, including ERROR): on the next edge all registers return to their reset values; no partial update of `mpc`/`mir`.
- Simultaneous JAMN and JAMZ: their effects OR together on bit 8.
- JMPC with NA[7:0]≠0: the result is the bitwise OR of NA[7:0] and `mbr`.

## Timing
- `exec_en` is combinational from state and `stall`.
- `cs_addr` is combinational from `mir`, `n`, `z` and `mbr`, so the critical path runs ALU → `cs_addr` → `cs_data` → MIR.
- After reset deasserts, the first executable microinstruction is in `mir` one cycle later (LOAD takes 1 cycle).
- Steady state executes one microinstruction per cycle; each stalled cycle adds one cycle of latency.
- `n_flag`/`z_flag` lag the ALU by one cycle and update only on executed cycles.

## Structure
- Shared definitions header additions:
  - `MPC_BITS`, `MIR_BITS`
  - MIR field offset constants
  - `seq_state_t` enum {LOAD, RUN, WAIT, ERROR}
- Sub-module `mpc_next_logic` (purely combinational): inputs are the MIR JAM/NA fields, `n`, `z` and `mbr`; output is `nxt`.
- Top level holds the FSM, the watchdog counter (`$clog2(WAIT_MAX+1)` bits) and the MIR/MPC/flag registers.

## Test plan
- **Reset/LOAD:** hold `reset_n`=0 for 2 cycles; `cs_data` at address 0 = 36'h0A5000000.
  - During reset: `mpc`=0, `mir`=0, `exec_en`=0.
  - One cycle after release: `mir`=36'h0A5000000, `exec_en`=1.
- **JAMZ:** MIR NA=9'h005, JAMZ=1, `z`=1 → `cs_addr`=9'h105 and `z_flag`=1 after the edge. With `z`=0 → 9'h005.
- **JMPC:** NA=9'h000, JMPC=1, `mbr`=8'h60 → `cs_addr`=9'h060. With NA=9'h001, `mbr`=8'h60 → 9'h061.
- **Stall hold:** assert `stall` for 3 cycles mid-program.
  - `mpc`/`mir`/flags unchanged and `exec_en`=0 for those 3 cycles.
  - Program resumes at the same word; `cnt` returns to 0.
- **Watchdog:** hold `stall` for 15 cycles → no timeout. Hold it for 16 cycles → `timeout`=1 from the next cycle, held after `stall` drops, cleared only by `reset_n`=0.
- **Reset mid-stall:** reset asserted while in WAIT with `cnt`=7 → all reset values next cycle, then LOAD, then normal run.
